aes128_iter_core: RTL and testbench

- Iterative AES-128 encryption engine with valid/ready handshakes on input and output.
- Successor to the fixed single-shot AES128 top. Round datapath is unrolled by a parameter, so area and latency trade off.
- Round keys are expanded on the fly, alongside the state.
- Sits between a block-feeding front end (DMA/stream) and a ciphertext consumer; one block in flight at a time.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_round_unit.sv | 58 +++++
 rtl/aes128_iter_core.sv | 124 ++++++++++++
 tb/tb_aes128_iter_core.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box lookup, GF(2^8) helpers, the rcon table,
// the core FSM state type and the fixed block/round constants.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int BLOCK_W    = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants for rounds 1..10, round 1 in the most significant byte.
    localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
    endfunction

    // Multiply by x in GF(2^8), reducing with the AES polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Round constant for round idx (1..10).
    function automatic logic [7:0] rcon_at(input int idx);
        return RCON_TABLE[79 - 8 * (idx - 1) -: 8];
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES-128 encryption round together with the matching
// key-schedule step. The next round key is derived first and used as the
// AddRoundKey operand of this same round.
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] key_in,
    input  logic [7:0]         rcon_in,
    input  logic               is_last,
    output logic [BLOCK_W-1:0] state_out,
    output logic [BLOCK_W-1:0] key_out,
    output logic [7:0]         rcon_out
);

    logic [31:0] temp_w;
    logic [31:0] nw0, nw1, nw2, nw3;
    logic [7:0]  sr [16];
    logic [7:0]  mc [16];

    // Key schedule: RotWord, SubWord and rcon on the last word, then the xor chain.
    always_comb begin
        temp_w = {sbox(key_in[23:16]), sbox(key_in[15:8]),
                  sbox(key_in[7:0]),   sbox(key_in[31:24])} ^ {rcon_in, 24'h000000};
        nw0      = key_in[127:96] ^ temp_w;
        nw1      = key_in[95:64]  ^ nw0;
        nw2      = key_in[63:32]  ^ nw1;
        nw3      = key_in[31:0]   ^ nw2;
        key_out  = {nw0, nw1, nw2, nw3};
        rcon_out = xtime(rcon_in);
    end

    // SubBytes and ShiftRows: byte k = row k%4, column k/4; row r rotates left by r.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sr[k] = sbox(state_in[127 - 8 * ((4 * (((k / 4) + (k % 4)) % 4)) + (k % 4)) -: 8]);
        end
    end

    // MixColumns on each column of the shifted state.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = gf_mul2(sr[4*c]) ^ gf_mul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ gf_mul2(sr[4*c+1]) ^ gf_mul3(sr[4*c+2]) ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gf_mul2(sr[4*c+2]) ^ gf_mul3(sr[4*c+3]);
            mc[4*c+3] = gf_mul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gf_mul2(sr[4*c+3]);
        end
    end

    // AddRoundKey; the final round skips MixColumns.
    always_comb begin
        state_out = '0;
        for (int k = 0; k < 16; k++) begin
            state_out[127 - 8 * k -: 8] = (is_last ? sr[k] : mc[k]) ^ key_out[127 - 8 * k -: 8];
        end
    end

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core. ROUNDS_PER_CYCLE round units are chained
// combinationally and iterated over the 10 rounds; one block in flight, with
// valid/ready handshakes on both sides.
module aes128_iter_core
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [BLOCK_W-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    generate
        if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
            ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
            $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
        end
    endgenerate

    state_t             state_q, state_d;
    logic               alive_q;
    logic [BLOCK_W-1:0] st_q;
    logic [BLOCK_W-1:0] key_q;
    logic [7:0]         rcon_q;
    logic [3:0]         rnd_q;
    logic               accept;
    logic               last_step;

    logic [BLOCK_W-1:0] st_chain   [ROUNDS_PER_CYCLE+1];
    logic [BLOCK_W-1:0] key_chain  [ROUNDS_PER_CYCLE+1];
    logic [7:0]         rcon_chain [ROUNDS_PER_CYCLE+1];

    assign st_chain[0]   = st_q;
    assign key_chain[0]  = key_q;
    assign rcon_chain[0] = rcon_q;

    // Stage i computes round rnd_q + i + 1; only round 10 drops MixColumns.
    generate
        for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
            aes_round_unit u_round (
                .state_in  (st_chain[i]),
                .key_in    (key_chain[i]),
                .rcon_in   (rcon_chain[i]),
                .is_last   (rnd_q == 4'(NUM_ROUNDS - 1 - i)),
                .state_out (st_chain[i+1]),
                .key_out   (key_chain[i+1]),
                .rcon_out  (rcon_chain[i+1])
            );
        end
    endgenerate

    assign last_step = (rnd_q == 4'(NUM_ROUNDS - ROUNDS_PER_CYCLE));

    // State register; alive_q holds in_ready low until the first edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = alive_q;
                accept   = alive_q & in_valid;
                if (accept) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in RUN, publish and hold the result in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q      <= '0;
            key_q     <= '0;
            rcon_q    <= 8'h00;
            rnd_q     <= 4'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            st_q   <= in_data ^ in_key;
            key_q  <= in_key;
            rcon_q <= 8'h01;
            rnd_q  <= 4'd0;
        end else if (state_q == RUN) begin
            st_q   <= st_chain[ROUNDS_PER_CYCLE];
            key_q  <= key_chain[ROUNDS_PER_CYCLE];
            rcon_q <= rcon_chain[ROUNDS_PER_CYCLE];
            rnd_q  <= rnd_q + 4'(ROUNDS_PER_CYCLE);
            if (last_step) begin
                out_data  <= st_chain[ROUNDS_PER_CYCLE];
                out_valid <= 1'b1;
            end
        end else if (state_q == DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core: one instance per legal ROUNDS_PER_CYCLE
// (1, 2, 5, 10) driven from a single linear sequence of steps.
module tb_aes128_iter_core;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_valid;
    logic [3:0]   out_ready;
    wire  [3:0]   in_ready;
    wire  [3:0]   out_valid;
    wire  [3:0]   busy;
    logic [127:0] in_data  [4];
    logic [127:0] in_key   [4];
    wire  [127:0] out_data [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes128_iter_core #(.ROUNDS_PER_CYCLE(1)) u_r1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_key(in_key[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0])
    );

    aes128_iter_core #(.ROUNDS_PER_CYCLE(2)) u_r2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_key(in_key[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1])
    );

    aes128_iter_core #(.ROUNDS_PER_CYCLE(5)) u_r5 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_key(in_key[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .busy(busy[2])
    );

    aes128_iter_core #(.ROUNDS_PER_CYCLE(10)) u_r10 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .in_key(in_key[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_data(out_data[3]), .busy(busy[3])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a block, wait (bounded) for in_ready, and return just after the accepting edge.
    task automatic send(input int idx, input logic [127:0] pt, input logic [127:0] key);
        int n;
        n = 0;
        in_data[idx]  = pt;
        in_key[idx]   = key;
        in_valid[idx] = 1'b1;
        while (!in_ready[idx] && n < 20) begin
            step();
            n++;
        end
        chk("accept_wait", 128'(n < 20), 128'(1));
        step();
        in_valid[idx] = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid is seen (bounded).
    task automatic wait_out(input int idx, output int cyc);
        cyc = 0;
        while (!out_valid[idx] && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int acc2;
        int lat1;

        reset     = 1'b1;
        in_valid  = 4'h0;
        out_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            in_data[i] = '0;
            in_key[i]  = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_data", out_data[0], 128'h0);
        reset = 1'b0;
        step();
        chk("post_rst_in_ready", 128'(in_ready), 128'hf);

        // Test 1: R=1, FIPS-197 C.1 vector
        out_ready = 4'hf;
        send(0, P1, K1);
        chk("t1_busy", 128'(busy[0]), 128'(1));
        wait_out(0, cyc);
        chk("t1_latency", 128'(cyc), 128'(10));
        chk("t1_data", out_data[0], C1);
        step();
        chk("t1_valid_one_cycle", 128'(out_valid[0]), 128'(0));
        chk("t1_in_ready_back", 128'(in_ready[0]), 128'(1));
        chk("t1_data_kept", out_data[0], C1);

        // Test 2: R=2, 5, 10 with the FIPS-197 B vector
        send(1, P2, K2);
        wait_out(1, cyc);
        chk("t2_r2_latency", 128'(cyc), 128'(5));
        chk("t2_r2_data", out_data[1], C2);
        step();
        send(2, P2, K2);
        wait_out(2, cyc);
        chk("t2_r5_latency", 128'(cyc), 128'(2));
        chk("t2_r5_data", out_data[2], C2);
        step();
        send(3, P2, K2);
        wait_out(3, cyc);
        chk("t2_r10_latency", 128'(cyc), 128'(1));
        chk("t2_r10_data", out_data[3], C2);
        step();
        chk("t2_r10_valid_drop", 128'(out_valid[3]), 128'(0));

        // Test 3: backpressure holds DONE with stable outputs
        out_ready[0] = 1'b0;
        send(0, P1, K1);
        wait_out(0, cyc);
        chk("t3_latency", 128'(cyc), 128'(10));
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t3_hold_ctrl", 128'({out_valid[0], in_ready[0], busy[0]}), 128'(3'b100));
            chk("t3_hold_data", out_data[0], C1);
        end
        out_ready[0] = 1'b1;
        step();
        chk("t3_release_valid", 128'(out_valid[0]), 128'(0));
        chk("t3_release_in_ready", 128'(in_ready[0]), 128'(1));
        step();
        chk("t3_single_handshake", 128'(out_valid[0]), 128'(0));

        // Test 4: back-to-back with in_valid held high
        in_data[0]  = P1;
        in_key[0]   = K1;
        in_valid[0] = 1'b1;
        chk("t4_ready_first", 128'(in_ready[0]), 128'(1));
        step();
        in_data[0] = P2;
        in_key[0]  = K2;
        acc2 = -1;
        lat1 = -1;
        for (int c = 1; c <= 30 && acc2 < 0; c++) begin
            if (in_ready[0]) acc2 = c;
            step();
            if (lat1 < 0 && out_valid[0]) begin
                lat1 = c;
                chk("t4_first_data", out_data[0], C1);
            end
        end
        in_valid[0] = 1'b0;
        chk("t4_first_latency", 128'(lat1), 128'(10));
        chk("t4_second_accept", 128'(acc2), 128'(12));
        wait_out(0, cyc);
        chk("t4_second_latency", 128'(cyc), 128'(10));
        chk("t4_second_data", out_data[0], C2);
        step();

        // Test 5: reset during RUN
        send(0, P1, K1);
        repeat (4) step();
        chk("t5_busy_before", 128'(busy[0]), 128'(1));
        reset = 1'b1;
        #1;
        chk("t5_async_valid", 128'(out_valid[0]), 128'(0));
        chk("t5_async_busy", 128'(busy[0]), 128'(0));
        chk("t5_async_in_ready", 128'(in_ready[0]), 128'(0));
        step();
        reset = 1'b0;
        step();
        chk("t5_in_ready_after", 128'(in_ready[0]), 128'(1));
        chk("t5_no_stale", 128'(out_valid[0]), 128'(0));
        send(0, P2, K2);
        wait_out(0, cyc);
        chk("t5_latency", 128'(cyc), 128'(10));
        chk("t5_data", out_data[0], C2);
        step();

        // Test 6: inputs changed right after acceptance do not disturb the block
        send(0, P1, K1);
        in_data[0] = P2;
        in_key[0]  = K2;
        wait_out(0, cyc);
        chk("t6_latency", 128'(cyc), 128'(10));
        chk("t6_data", out_data[0], C1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
